// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C register target.
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } i2c_slv_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_in_sync.sv
// Pad synchronizer for scl/sda plus edge and START/STOP detection on the
// synchronized levels.
`timescale 1ns/1ps
module i2c_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Idle bus level is high, so reset preloads ones to avoid a false START.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_d;
  assign o_scl_fall = ~w_scl & r_scl_d;
  // scl must be high on both samples so an sda edge racing an scl edge is not misread.
  assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing NUM_REGS byte registers behind an auto-incrementing
// pointer; sda is driven open-drain, scl is never stretched.
`timescale 1ns/1ps
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe,
  output logic                        busy,
  output logic                        wr_stb,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data
);

  localparam int PW = $clog2(NUM_REGS);

  logic           w_sda;
  logic           w_scl_rise;
  logic           w_scl_fall;
  logic           w_start;
  logic           w_stop;

  i2c_slv_state_t r_state;
  logic [7:0]     r_shift;
  logic [3:0]     r_cnt;
  logic [PW-1:0]  r_ptr;
  logic           r_rw;
  logic           r_ack_drv;
  logic [7:0]     r_regs [NUM_REGS];

  logic [7:0]     w_byte;
  logic [PW-1:0]  w_ptr_nxt;
  logic [7:0]     w_rd_cur;
  logic [7:0]     w_rd_nxt;
  logic           w_addr_hit;

  i2c_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk     (PCLK),
    .i_rst_n   (PRESETn),
    .i_scl     (scl_i),
    .i_sda     (sda_i),
    .o_sda     (w_sda),
    .o_scl_rise(w_scl_rise),
    .o_scl_fall(w_scl_fall),
    .o_start   (w_start),
    .o_stop    (w_stop)
  );

  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_ptr_nxt  = r_ptr + 1'b1;
  assign w_rd_cur   = r_regs[r_ptr];
  assign w_rd_nxt   = r_regs[w_ptr_nxt];
  // Address 0 is the general call, which this target never claims.
  assign w_addr_hit = (w_byte[7:1] == SLAVE_ADDR) && (w_byte[7:1] != 7'd0);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'h00;
      r_cnt     <= 4'd0;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_ack_drv <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      wr_stb <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_cnt     <= 4'd0;
        r_ack_drv <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_ack_drv <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_IGNORE: begin
            sda_oe <= 1'b0;
          end

          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                r_cnt <= 4'd0;
                if (w_addr_hit) begin
                  r_state <= S_ADDR_ACK;
                  r_rw    <= w_byte[0];
                  busy    <= 1'b1;
                end else begin
                  r_state <= S_IGNORE;
                  busy    <= 1'b0;
                end
              end
            end
          end

          S_PTR: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                r_cnt   <= 4'd0;
                r_ptr   <= w_byte[PW-1:0];
                r_state <= S_PTR_ACK;
              end
            end
          end

          S_WDATA: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                r_cnt         <= 4'd0;
                r_regs[r_ptr] <= w_byte;
                wr_stb        <= 1'b1;
                wr_addr       <= r_ptr;
                wr_data       <= w_byte;
                r_ptr         <= w_ptr_nxt;
                r_state       <= S_WDATA_ACK;
              end
            end
          end

          // ACK slot spans one scl period: asserted on the first fall, released on the second.
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_ack_drv <= 1'b1;
                sda_oe    <= ~ACK;
              end else begin
                r_ack_drv <= 1'b0;
                sda_oe    <= 1'b0;
                r_cnt     <= 4'd0;
                if (r_state == S_ADDR_ACK && r_rw) begin
                  // The fall that ends the ACK also launches the first read bit.
                  sda_oe  <= ~w_rd_cur[7];
                  r_shift <= {w_rd_cur[6:0], 1'b0};
                  r_cnt   <= 4'd1;
                  r_state <= S_RDATA;
                end else if (r_state == S_ADDR_ACK) begin
                  r_state <= S_PTR;
                end else begin
                  r_state <= S_WDATA;
                end
              end
            end
          end

          S_RDATA: begin
            if (w_scl_fall) begin
              if (r_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                r_cnt   <= 4'd0;
                r_state <= S_RDATA_ACK;
              end else begin
                sda_oe  <= ~r_shift[7];
                r_shift <= {r_shift[6:0], 1'b0};
                r_cnt   <= r_cnt + 4'd1;
              end
            end
          end

          S_RDATA_ACK: begin
            sda_oe <= 1'b0;
            if (w_scl_rise) begin
              if (w_sda == ACK) begin
                r_ptr   <= w_ptr_nxt;
                r_shift <= w_rd_nxt;
                r_cnt   <= 4'd0;
                r_state <= S_RDATA;
              end else begin
                busy    <= 1'b0;
                r_state <= S_IGNORE;
              end
            end
          end

          default: begin
            sda_oe  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench: bit-banged I2C master with a wired-AND sda line.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

  localparam int Q = 40;

  logic       PCLK    = 1'b0;
  logic       PRESETn = 1'b0;
  logic       scl_m   = 1'b1;
  logic       sda_m   = 1'b1;
  logic       sda_oe;
  logic       busy;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  wire        sda_line = sda_m & ~sda_oe;

  int n_chk  = 0;
  int n_fail = 0;
  int wl_a[$];
  int wl_d[$];
  bit seen_oe;

  always #5 PCLK = ~PCLK;

  i2c_slave_regs #(
    .SLAVE_ADDR (7'h50),
    .NUM_REGS   (16),
    .SYNC_STAGES(2)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .scl_i  (scl_m),
    .sda_i  (sda_line),
    .sda_oe (sda_oe),
    .busy   (busy),
    .wr_stb (wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always @(negedge PCLK) begin
    if (wr_stb) begin
      wl_a.push_back(int'(wr_addr));
      wl_d.push_back(int'(wr_data));
    end
    if (sda_oe) seen_oe = 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bit_x(input logic b, output logic r);
    sda_m = b;
    #Q scl_m = 1'b1;
    #Q r = sda_line;
    #Q scl_m = 1'b0;
    #(2*Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
    #(2*Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #(2*Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output int ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, r);
    ack = (r == 1'b0) ? 1 : 0;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
    bit_x(nack, r);
  endtask

  // Set pointer, repeated start, read n bytes (ACK all but the last), STOP.
  task automatic read_check(input string nm, input logic [7:0] ptr, input int n,
                            input logic [7:0] e0, input logic [7:0] e1);
    int         ack;
    logic [7:0] d;
    i2c_start();
    wr_byte(8'hA0, ack);  chk({nm, " addr_w ack"}, ack, 1);
    wr_byte(ptr, ack);    chk({nm, " ptr ack"}, ack, 1);
    i2c_start();
    wr_byte(8'hA1, ack);  chk({nm, " addr_r ack"}, ack, 1);
    rd_byte((n == 1), d); chk({nm, " rd0"}, int'(d), int'(e0));
    if (n > 1) begin
      rd_byte(1'b1, d);   chk({nm, " rd1"}, int'(d), int'(e1));
    end
    chk({nm, " sda released after nack"}, int'(sda_oe), 0);
    chk({nm, " busy after nack"}, int'(busy), 0);
    i2c_stop();
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    int         a0;
    int         a1;
  } vec_t;

  vec_t vt[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ack;
    logic       r;
    logic [7:0] pat;

    vt[0] = '{ptr: 8'h03, d0: 8'h11, d1: 8'h22, a0: 3,  a1: 4};
    vt[1] = '{ptr: 8'h0F, d0: 8'hAA, d1: 8'hBB, a0: 15, a1: 0};
    vt[2] = '{ptr: 8'h17, d0: 8'h5A, d1: 8'hA5, a0: 7,  a1: 8};
    vt[3] = '{ptr: 8'h05, d0: 8'h3C, d1: 8'hC3, a0: 5,  a1: 6};
    vt[4] = '{ptr: 8'hFE, d0: 8'h01, d1: 8'h80, a0: 14, a1: 15};

    repeat (3) @(posedge PCLK);
    #1;
    chk("reset sda_oe", int'(sda_oe), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset wr_stb", int'(wr_stb), 0);
    chk("reset wr_addr", int'(wr_addr), 0);
    chk("reset wr_data", int'(wr_data), 0);
    @(negedge PCLK) PRESETn = 1'b1;
    repeat (5) @(posedge PCLK);

    for (int v = 0; v < 5; v++) begin
      wl_a.delete();
      wl_d.delete();
      i2c_start();
      wr_byte(8'hA0, ack);     chk($sformatf("v%0d addr ack", v), ack, 1);
      chk($sformatf("v%0d busy", v), int'(busy), 1);
      wr_byte(vt[v].ptr, ack); chk($sformatf("v%0d ptr ack", v), ack, 1);
      wr_byte(vt[v].d0, ack);  chk($sformatf("v%0d d0 ack", v), ack, 1);
      wr_byte(vt[v].d1, ack);  chk($sformatf("v%0d d1 ack", v), ack, 1);
      i2c_stop();
      chk($sformatf("v%0d busy after stop", v), int'(busy), 0);
      chk($sformatf("v%0d wr_stb count", v), wl_a.size(), 2);
      if (wl_a.size() == 2) begin
        chk($sformatf("v%0d wr_addr0", v), wl_a[0], vt[v].a0);
        chk($sformatf("v%0d wr_data0", v), wl_d[0], int'(vt[v].d0));
        chk($sformatf("v%0d wr_addr1", v), wl_a[1], vt[v].a1);
        chk($sformatf("v%0d wr_data1", v), wl_d[1], int'(vt[v].d1));
      end
      read_check($sformatf("v%0d readback", v), vt[v].ptr, 2, vt[v].d0, vt[v].d1);
    end

    // Wrapped read straddling reg15 -> reg0.
    read_check("wrap read", 8'h0F, 2, 8'h80, 8'hBB);

    // Foreign address: bus stays untouched.
    wl_a.delete();
    seen_oe = 1'b0;
    i2c_start();
    wr_byte(8'hB0, ack); chk("mismatch addr nack", ack, 0);
    chk("mismatch busy", int'(busy), 0);
    wr_byte(8'h55, ack); chk("mismatch data nack", ack, 0);
    i2c_stop();
    chk("mismatch sda never driven", int'(seen_oe), 0);
    chk("mismatch no wr_stb", wl_a.size(), 0);
    chk("mismatch busy end", int'(busy), 0);

    // General call address.
    seen_oe = 1'b0;
    i2c_start();
    wr_byte(8'h00, ack); chk("gencall nack", ack, 0);
    i2c_stop();
    chk("gencall sda never driven", int'(seen_oe), 0);

    // Byte aborted by STOP after 4 bits.
    wl_a.delete();
    i2c_start();
    wr_byte(8'hA0, ack); chk("abort addr ack", ack, 1);
    wr_byte(8'h05, ack); chk("abort ptr ack", ack, 1);
    pat = 8'hF0;
    for (int i = 7; i >= 4; i--) bit_x(pat[i], r);
    i2c_stop();
    chk("abort no wr_stb", wl_a.size(), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort sda_oe", int'(sda_oe), 0);
    read_check("abort reg5", 8'h05, 1, 8'h3C, 8'h00);

    // Reset while the address ACK is being driven.
    i2c_start();
    pat = 8'hA0;
    for (int i = 7; i >= 0; i--) bit_x(pat[i], r);
    chk("pre-reset ack driven", int'(sda_oe), 1);
    chk("pre-reset busy", int'(busy), 1);
    @(negedge PCLK) PRESETn = 1'b0;
    @(posedge PCLK);
    #1;
    chk("midreset sda_oe", int'(sda_oe), 0);
    chk("midreset busy", int'(busy), 0);
    repeat (2) @(posedge PCLK);
    scl_m = 1'b1;
    sda_m = 1'b1;
    @(negedge PCLK) PRESETn = 1'b1;
    repeat (5) @(posedge PCLK);
    read_check("post-reset reg0", 8'h00, 1, 8'h00, 8'h00);
    read_check("post-reset reg3", 8'h03, 2, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
